// File: rtl/bp_resolve_if.sv
// bp_resolve_if: EX resolution, prediction metadata and pre-IF redirect handshake.
interface bp_resolve_if #(
    parameter int PC_W = 32
);
    logic            ex_valid_i;
    logic            ex_is_br_i;
    logic [PC_W-1:0] ex_pc_i;
    logic            ex_taken_i;
    logic [PC_W-1:0] ex_target_i;
    logic            pred_valid_i;
    logic [1:0]      pred_state_i;
    logic            pred_btb_hit_i;
    logic [PC_W-1:0] pred_target_i;
    logic            redirect_ready_i;
    logic            redirect_valid_o;
    logic [PC_W-1:0] redirect_pc_o;

    modport slave (
        input  ex_valid_i, ex_is_br_i, ex_pc_i, ex_taken_i, ex_target_i,
        input  pred_valid_i, pred_state_i, pred_btb_hit_i, pred_target_i,
        input  redirect_ready_i,
        output redirect_valid_o, redirect_pc_o
    );

    modport master (
        output ex_valid_i, ex_is_br_i, ex_pc_i, ex_taken_i, ex_target_i,
        output pred_valid_i, pred_state_i, pred_btb_hit_i, pred_target_i,
        output redirect_ready_i,
        input  redirect_valid_o, redirect_pc_o
    );
endinterface

// File: rtl/bp_resolve.sv
// bp_resolve: branch resolution, mispredict redirect and registered PHT/BTB update bus.
module bp_resolve #(
    parameter int PC_W      = 32,
    parameter int PHT_IDX_W = 10,
    parameter int CNT_W     = 32
) (
    input  logic                          clk,
    input  logic                          resetn,
    bp_resolve_if.slave                   bus,
    output logic [2*PC_W+PHT_IDX_W+3:0]   bp_wbus_o,
    output logic [CNT_W-1:0]              br_cnt_o,
    output logic [CNT_W-1:0]              mis_cnt_o
);
    typedef enum logic {IDLE, REDIR} state_t;

    state_t                        state_q, state_d;
    logic [PC_W-1:0]               rpc_q, rpc_d;
    logic [2*PC_W+PHT_IDX_W+3:0]   wbus_q, wbus_d;
    logic [CNT_W-1:0]              br_q, br_d, mis_q, mis_d;
    logic                          fire, pred_taken, mis, btb_we;
    logic [1:0]                    base, nstate;

    // Branches seen while a redirect is pending are wrong-path and dropped.
    assign fire       = bus.ex_valid_i & bus.ex_is_br_i & (state_q == IDLE);
    assign pred_taken = bus.pred_valid_i & bus.pred_state_i[1] & bus.pred_btb_hit_i;
    assign mis        = (bus.ex_taken_i != pred_taken) |
                        (bus.ex_taken_i & pred_taken & (bus.pred_target_i != bus.ex_target_i));
    assign base       = bus.pred_valid_i ? bus.pred_state_i : 2'b01;
    assign btb_we     = bus.ex_taken_i & (~bus.pred_btb_hit_i | (bus.pred_target_i != bus.ex_target_i));

    always_comb begin
        nstate  = bus.ex_taken_i ? ((base == 2'b11) ? base : base + 2'b01)
                                 : ((base == 2'b00) ? base : base - 2'b01);
        state_d = (state_q == IDLE) ? ((fire & mis) ? REDIR : IDLE)
                                    : (bus.redirect_ready_i ? IDLE : REDIR);
        rpc_d   = (fire & mis) ? (bus.ex_taken_i ? bus.ex_target_i : bus.ex_pc_i + PC_W'(4)) : rpc_q;
        wbus_d  = fire ? {1'b1, bus.ex_pc_i[PHT_IDX_W+2:3], nstate, btb_we, bus.ex_pc_i, bus.ex_target_i}
                       : '0;
        br_d    = fire ? br_q + CNT_W'(1) : br_q;
        mis_d   = (fire & mis) ? mis_q + CNT_W'(1) : mis_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            rpc_q   <= '0;
            wbus_q  <= '0;
            br_q    <= '0;
            mis_q   <= '0;
        end else begin
            state_q <= state_d;
            rpc_q   <= rpc_d;
            wbus_q  <= wbus_d;
            br_q    <= br_d;
            mis_q   <= mis_d;
        end
    end

    assign bus.redirect_valid_o = (state_q == REDIR);
    assign bus.redirect_pc_o    = rpc_q;
    assign bp_wbus_o            = wbus_q;
    assign br_cnt_o             = br_q;
    assign mis_cnt_o            = mis_q;
endmodule

// File: tb/tb_bp_resolve.sv
// tb_bp_resolve: directed vectors for bp_resolve with hand-computed expectations.
module tb_bp_resolve;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [77:0] wbus;
    logic [31:0] br_cnt, mis_cnt;
    int          total = 0;
    int          bad = 0;

    bp_resolve_if #(.PC_W(32)) bus ();

    bp_resolve #(.PC_W(32), .PHT_IDX_W(10), .CNT_W(32)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .bus       (bus),
        .bp_wbus_o (wbus),
        .br_cnt_o  (br_cnt),
        .mis_cnt_o (mis_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                         input logic pv, input logic [1:0] ps, input logic hit, input logic [31:0] pt);
        bus.ex_valid_i     = v;
        bus.ex_is_br_i     = v;
        bus.ex_pc_i        = pc;
        bus.ex_taken_i     = tk;
        bus.ex_target_i    = tgt;
        bus.pred_valid_i   = pv;
        bus.pred_state_i   = ps;
        bus.pred_btb_hit_i = hit;
        bus.pred_target_i  = pt;
    endtask

    task automatic release_redirect();
        bus.redirect_ready_i = 1'b1;
        tick();
        bus.redirect_ready_i = 1'b0;
        check("rel_valid", bus.redirect_valid_o, 1'b0);
        check("rel_pht_we", wbus[77], 1'b0);
        check("rel_btb_we", wbus[64], 1'b0);
    endtask

    initial begin
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 2'b00, 1'b0, 32'h0);
        bus.redirect_ready_i = 1'b0;
        #3;
        check("rst_valid", bus.redirect_valid_o, 1'b0);
        check("rst_wbus", wbus, 78'h0);
        check("rst_br", br_cnt, 32'd0);
        check("rst_mis", mis_cnt, 32'd0);
        @(posedge clk);
        #2 resetn = 1'b1;
        tick();

        // 1: unpredicted taken branch
        drive(1'b1, 32'h1C000010, 1'b1, 32'h1C000100, 1'b0, 2'b00, 1'b0, 32'h0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 2'b00, 1'b0, 32'h0);
        check("t1_wbus", wbus, {1'b1, 10'h002, 2'b10, 1'b1, 32'h1C000010, 32'h1C000100});
        check("t1_valid", bus.redirect_valid_o, 1'b1);
        check("t1_rpc", bus.redirect_pc_o, 32'h1C000100);
        check("t1_br", br_cnt, 32'd1);
        check("t1_mis", mis_cnt, 32'd1);
        release_redirect();

        // 2: correct taken prediction, saturated state
        drive(1'b1, 32'h1C000040, 1'b1, 32'h1C000400, 1'b1, 2'b11, 1'b1, 32'h1C000400);
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 2'b00, 1'b0, 32'h0);
        check("t2_wbus", wbus, {1'b1, 10'h008, 2'b11, 1'b0, 32'h1C000040, 32'h1C000400});
        check("t2_valid", bus.redirect_valid_o, 1'b0);
        check("t2_br", br_cnt, 32'd2);
        check("t2_mis", mis_cnt, 32'd1);
        tick();
        check("idle_pht_we", wbus[77], 1'b0);

        // 3: predicted taken, actually not taken
        drive(1'b1, 32'h1C000020, 1'b0, 32'h1C000500, 1'b1, 2'b10, 1'b1, 32'h1C000500);
        tick();
        check("t3_wbus", wbus, {1'b1, 10'h004, 2'b01, 1'b0, 32'h1C000020, 32'h1C000500});
        check("t3_rpc", bus.redirect_pc_o, 32'h1C000024);
        check("t3_br", br_cnt, 32'd3);
        check("t3_mis", mis_cnt, 32'd2);

        // 4: redirect held while wrong-path branches arrive
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h1C000600 + 32'(i * 8), 1'b1, 32'h1C000700, 1'b0, 2'b00, 1'b0, 32'h0);
            tick();
            check("t4_valid", bus.redirect_valid_o, 1'b1);
            check("t4_rpc", bus.redirect_pc_o, 32'h1C000024);
            check("t4_pht_we", wbus[77], 1'b0);
            check("t4_btb_we", wbus[64], 1'b0);
            check("t4_br", br_cnt, 32'd3);
            check("t4_mis", mis_cnt, 32'd2);
        end
        bus.redirect_ready_i = 1'b1;
        tick();
        bus.redirect_ready_i = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 2'b00, 1'b0, 32'h0);
        check("t4_clear", bus.redirect_valid_o, 1'b0);
        check("t4_br_after", br_cnt, 32'd3);

        // 5: BTB target mismatch
        drive(1'b1, 32'h1C000080, 1'b1, 32'h1C000300, 1'b1, 2'b11, 1'b1, 32'h1C000200);
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 2'b00, 1'b0, 32'h0);
        check("t5_wbus", wbus, {1'b1, 10'h010, 2'b11, 1'b1, 32'h1C000080, 32'h1C000300});
        check("t5_rpc", bus.redirect_pc_o, 32'h1C000300);
        check("t5_valid", bus.redirect_valid_o, 1'b1);
        check("t5_mis", mis_cnt, 32'd3);
        release_redirect();

        // not-taken saturation at 00, correctly predicted
        drive(1'b1, 32'h1C000008, 1'b0, 32'h1C000900, 1'b1, 2'b00, 1'b1, 32'h1C000900);
        tick();
        check("sat0_wbus", wbus, {1'b1, 10'h001, 2'b00, 1'b0, 32'h1C000008, 32'h1C000900});
        check("sat0_valid", bus.redirect_valid_o, 1'b0);
        check("sat0_br", br_cnt, 32'd5);

        // fall-through PC wraps to zero
        drive(1'b1, 32'hFFFFFFFC, 1'b0, 32'h00001000, 1'b1, 2'b10, 1'b1, 32'h00001000);
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 2'b00, 1'b0, 32'h0);
        check("wrap_wbus", wbus, {1'b1, 10'h3FF, 2'b01, 1'b0, 32'hFFFFFFFC, 32'h00001000});
        check("wrap_rpc", bus.redirect_pc_o, 32'h0);
        check("wrap_valid", bus.redirect_valid_o, 1'b1);
        check("wrap_br", br_cnt, 32'd6);
        check("wrap_mis", mis_cnt, 32'd4);

        // 6: asynchronous reset mid-redirect
        #3 resetn = 1'b0;
        #1;
        check("arst_valid", bus.redirect_valid_o, 1'b0);
        check("arst_rpc", bus.redirect_pc_o, 32'h0);
        check("arst_wbus", wbus, 78'h0);
        check("arst_br", br_cnt, 32'd0);
        check("arst_mis", mis_cnt, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bp_resolve.md
Name: bp_resolve

Overview:
- Branch-resolution and predictor-update stage, downstream of the branch predictor.
- Receives each resolved branch from EX together with the prediction metadata the predictor issued for that fetch.
- Detects mispredictions, holds a redirect for pre-IF until it is accepted, and drives the registered PHT/BTB write bus back into the predictor.
- Keeps branch and mispredict performance counters.

Parameters:
PC_W, 32, PC and target width
PHT_IDX_W, 10, PHT index width (index = pc[12:3])
CNT_W, 32, performance counter width

Ports:
clk  in  1  clock, all state on rising edge
resetn  in  1  asynchronous, active-low reset
ex_valid_i  in  1  EX holds a valid instruction this cycle
ex_is_br_i  in  1  that instruction is a branch or jump
ex_pc_i  in  PC_W  branch PC
ex_taken_i  in  1  resolved direction
ex_target_i  in  PC_W  resolved target
pred_valid_i  in  1  prediction metadata valid for this branch
pred_state_i  in  2  PHT state read at fetch
pred_btb_hit_i  in  1  BTB hit at fetch
pred_target_i  in  PC_W  BTB target at fetch
redirect_ready_i  in  1  pre-IF accepts redirect
redirect_valid_o  out  1  redirect pending
redirect_pc_o  out  PC_W  correct next PC
bp_wbus_o  out  78  {pht_we, pht_idx[9:0], pht_state[1:0], btb_we, btb_pc[31:0], btb_target[31:0]}; PHT fields in the MSBs
br_cnt_o  out  CNT_W  resolved branches
mis_cnt_o  out  CNT_W  mispredicts

Behaviour:
- Reset (async, resetn=0): all outputs and registers 0.
- PHT state encoding: 00 SNT, 01 WNT, 10 WT, 11 ST.
- fire = ex_valid_i & ex_is_br_i & !redirect_valid_o.
- While a redirect is pending, branches are wrong-path and ignored: no update, no count, no new redirect.
- Predicted direction: pred_taken = pred_valid_i & pred_state_i[1] & pred_btb_hit_i.
- Mispredict when either holds:
  - ex_taken_i != pred_taken, or
  - ex_taken_i & pred_taken & (pred_target_i != ex_target_i).
- Base PHT state: pred_state_i if pred_valid_i, else 01.
- New PHT state: base state saturating +1 if taken, saturating -1 if not taken. 11 stays 11 on taken; 00 stays 00 on not-taken.
- BTB write needed when ex_taken_i & (!pred_btb_hit_i | pred_target_i != ex_target_i).
- Cycle after fire:
  - pht_we=1, pht_idx=ex_pc_i[12:3], pht_state=new state.
  - btb_we=1 only if a BTB write was needed; btb_pc=ex_pc_i, btb_target=ex_target_i.
  - The write bus is one-cycle registered. Both we bits are 0 in any cycle not following a fire.
- Mispredict on fire:
  - Next cycle redirect_valid_o=1.
  - redirect_pc_o = ex_taken_i ? ex_target_i : ex_pc_i+4. The add is modulo 2^PC_W; 0xFFFFFFFC+4 = 0.
- Redirect handshake:
  - redirect_valid_o and redirect_pc_o stay stable until a cycle with redirect_ready_i=1.
  - That cycle is the transfer; redirect_valid_o clears next cycle.
  - A fire is possible again in the cycle after the clear.
- Counters:
  - br_cnt_o increments on every fire.
  - mis_cnt_o increments on a fire that mispredicts.
  - Both wrap modulo 2^CNT_W.
  - Both update one cycle after fire, aligned with bp_wbus_o.
- Asserting resetn=0 mid-redirect clears the pending redirect immediately; no write is issued.

Test Plan:
1. Reset, then pc=0x1C000010, taken=1, target=0x1C000100, pred_valid=0 -> next cycle:
   - pht_we=1, idx=0x002, state=10;
   - btb_we=1 with pc/target as given;
   - redirect_valid_o=1, redirect_pc_o=0x1C000100; br_cnt=1, mis_cnt=1.
2. Correct taken prediction: state=11, btb_hit=1, pred_target=ex_target, taken=1 ->
   - pht_state=11 (saturated), btb_we=0;
   - no redirect; br_cnt increments, mis_cnt unchanged.
3. Predicted taken, actually not taken, pc=0x1C000020, state=10, hit=1 ->
   - redirect_pc_o=0x1C000024, pht_state=01, btb_we=0.
4. Hold redirect_ready_i=0 for 3 cycles while EX presents branches ->
   - redirect_valid_o and redirect_pc_o stay stable;
   - all pht_we/btb_we stay 0 and counters are frozen;
   - ready=1 -> valid clears next cycle.
5. Target mismatch: taken, hit=1, pred_target=0x1C000200, ex_target=0x1C000300, state=11 ->
   - mispredict, redirect to 0x1C000300;
   - btb_we=1 with target 0x1C000300; pht_state=11.
6. Drive resetn low asynchronously mid-cycle while redirect pending -> redirect_valid_o, bp_wbus_o and counters go to 0 without waiting for clk.
